// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port between the in-order WB stage
//   and a long-latency unit (LLU). WB has priority; LLU results are queued and
//   drained in idle WB slots. A starved or full queue forces a drain by
//   stalling the pipeline. A pending-rd scoreboard lets ID interlock on queued
//   LLU destinations.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   wb_regwrite/wb_rd/wb_data  WB stage write request
//   llu_valid/llu_ready        LLU result handshake (valid & ready = accept)
//   llu_rd/llu_data            LLU result destination and value
//   id_rs1/id_rs2              ID source registers for the pending check
//   rf_we/rf_rd/rf_wdata       register-file write port
//   pipe_stall                 hold IF..WB; WB write is not performed
//   pend_hit                   nonzero id_rs1/id_rs2 matches a queued LLU rd
module wb_port_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            llu_valid,
  output logic            llu_ready,
  input  logic [4:0]      llu_rd,
  input  logic [XLEN-1:0] llu_data,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic            pipe_stall,
  output logic            pend_hit
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, FORCE} state_t;

  state_t            state, state_next;
  logic [4:0]        q_rd   [DEPTH];
  logic [XLEN-1:0]   q_data [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, count_next;
  logic [SW-1:0]     starve;
  logic              wb_busy, push, pop, rf_we_raw;

  assign wb_busy   = wb_regwrite && (wb_rd != '0);
  // Ready depends on registered count only, so a full queue never accepts
  // even when a pop happens in the same cycle.
  assign llu_ready = (count < CW'(DEPTH));
  // x0 results are handshaken but never stored.
  assign push      = llu_valid && llu_ready && (llu_rd != '0);

  // Write-port mux and pop decision
  always_comb begin
    pop        = 1'b0;
    rf_we_raw  = 1'b0;
    rf_rd      = wb_rd;
    rf_wdata   = wb_data;
    pipe_stall = 1'b0;
    unique case (state)
      IDLE: begin
        rf_we_raw = wb_busy;
      end
      DRAIN: begin
        if (!wb_busy) begin
          pop       = (count != '0);
          rf_we_raw = pop;
          rf_rd     = q_rd[rd_ptr];
          rf_wdata  = q_data[rd_ptr];
        end else begin
          rf_we_raw = 1'b1;
        end
      end
      FORCE: begin
        pipe_stall = 1'b1;
        pop        = (count != '0);
        rf_we_raw  = pop;
        rf_rd      = q_rd[rd_ptr];
        rf_wdata   = q_data[rd_ptr];
      end
      default: begin
        rf_we_raw = 1'b0;
      end
    endcase
  end

  // Gated so that no write escapes while reset is held, whatever WB presents.
  assign rf_we = rf_we_raw && rst_n;

  assign count_next = count + CW'(push) - CW'(pop);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (push) state_next = DRAIN;
      DRAIN: begin
        if (count_next == '0)
          state_next = IDLE;
        else if ((count_next == CW'(DEPTH)) ||
                 ((starve == SW'(STARVE_LIMIT - 1)) && !pop))
          state_next = FORCE;
      end
      FORCE: if (count_next == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      starve <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if ((state_next == IDLE) || pop)
        starve <= '0;
      else if ((state == DRAIN) && wb_busy && (starve < SW'(STARVE_LIMIT - 1)))
        starve <= starve + 1'b1;
    end
  end

  // Payload storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= llu_rd;
      q_data[wr_ptr] <= llu_data;
    end
  end

  // An entry is valid when its distance from the read pointer is below count;
  // pointer subtraction wraps naturally because DEPTH is a power of two.
  always_comb begin
    logic [AW-1:0] off;
    pend_hit = 1'b0;
    off      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_ptr;
      if (CW'(off) < count) begin
        if ((id_rs1 != '0) && (q_rd[i] == id_rs1)) pend_hit = 1'b1;
        if ((id_rs2 != '0) && (q_rd[i] == id_rs2)) pend_hit = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        llu_valid;
  logic        llu_ready;
  logic [4:0]  llu_rd;
  logic [31:0] llu_data;
  logic [4:0]  id_rs1, id_rs2;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        pipe_stall;
  logic        pend_hit;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        stall;
    logic        ready;
    logic        pend;
    string       tag;
  } exp_t;

  exp_t sb[$];

  wb_port_arbiter #(.XLEN(32), .DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .llu_valid(llu_valid), .llu_ready(llu_ready),
    .llu_rd(llu_rd), .llu_data(llu_data),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .pipe_stall(pipe_stall), .pend_hit(pend_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per stimulus cycle, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".rf_we"},      32'(rf_we),      32'(e.we));
      if (e.we) begin
        chk({e.tag, ".rf_rd"},    32'(rf_rd),      32'(e.rd));
        chk({e.tag, ".rf_wdata"}, rf_wdata,        e.data);
      end
      chk({e.tag, ".pipe_stall"}, 32'(pipe_stall), 32'(e.stall));
      chk({e.tag, ".llu_ready"},  32'(llu_ready),  32'(e.ready));
      chk({e.tag, ".pend_hit"},   32'(pend_hit),   32'(e.pend));
    end else if (rf_we) begin
      chk("unexpected_write", 32'(rf_we), 32'd0);
    end
  end

  // One clock cycle of stimulus plus its hand-computed expected response.
  task automatic cyc(input string tag, input logic rst,
                     input logic wbw, input logic [4:0] wrd, input logic [31:0] wd,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                     input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic ewe, input logic [4:0] erd, input logic [31:0] ed,
                     input logic est, input logic erdy, input logic epend);
    exp_t e;
    @(posedge clk);
    #1;
    wb_regwrite = wbw; wb_rd = wrd; wb_data = wd;
    llu_valid = lv; llu_rd = lrd; llu_data = ld;
    id_rs1 = rs1; id_rs2 = rs2;
    rst_n = rst;
    e.we = ewe; e.rd = erd; e.data = ed;
    e.stall = est; e.ready = erdy; e.pend = epend; e.tag = tag;
    sb.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
    llu_valid = 1'b0; llu_rd = '0; llu_data = '0;
    id_rs1 = '0; id_rs2 = '0;

    // Reset: WB request must not reach the port while reset is held.
    cyc("rst0", 0, 1, 5, 32'h11, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);
    cyc("rst1", 0, 0, 0, 0,      0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);

    // 1: WB only, and a WB write to x0 is dropped.
    cyc("wb",   1, 1, 5, 32'h11, 0, 0, 0, 0, 0,  1, 5, 32'h11, 0, 1, 0);
    cyc("wbx0", 1, 1, 0, 32'h22, 0, 0, 0, 0, 0,  0, 0, 0,      0, 1, 0);

    // 2: LLU drains in the next idle slot; same-cycle input never hits pend.
    cyc("llu_acc", 1, 0, 0, 0, 1, 7, 32'hAB, 7, 0,  0, 0, 0,      0, 1, 0);
    cyc("llu_wr",  1, 0, 0, 0, 0, 0, 0,      7, 0,  1, 7, 32'hAB, 0, 1, 1);
    cyc("llu_idl", 1, 0, 0, 0, 0, 0, 0,      7, 0,  0, 0, 0,      0, 1, 0);

    // 3: starvation -> one forced cycle, WB write suppressed, then WB resumes.
    cyc("st_acc", 1, 1, 1, 32'h100, 1, 9, 32'h99, 0, 0,  1, 1, 32'h100, 0, 1, 0);
    for (int i = 1; i <= 8; i++)
      cyc("st_wb", 1, 1, 5'(i + 1), 32'h100 + 32'(i), 0, 0, 0, 9, 0,
          1, 5'(i + 1), 32'h100 + 32'(i), 0, 1, 1);
    cyc("st_frc", 1, 1, 20, 32'hDEAD, 0, 0, 0, 9, 0,  1, 9,  32'h99,   1, 1, 1);
    cyc("st_wb2", 1, 1, 20, 32'hDEAD, 0, 0, 0, 9, 0,  1, 20, 32'hDEAD, 0, 1, 0);

    // 4: full queue -> four forced pops in order; offered rd=14 is refused.
    cyc("fl_a0", 1, 1, 2, 32'h200, 1, 10, 32'hA0, 0, 0,  1, 2, 32'h200, 0, 1, 0);
    cyc("fl_a1", 1, 1, 2, 32'h201, 1, 11, 32'hA1, 0, 0,  1, 2, 32'h201, 0, 1, 0);
    cyc("fl_a2", 1, 1, 2, 32'h202, 1, 12, 32'hA2, 0, 0,  1, 2, 32'h202, 0, 1, 0);
    cyc("fl_a3", 1, 1, 2, 32'h203, 1, 13, 32'hA3, 0, 0,  1, 2, 32'h203, 0, 1, 0);
    cyc("fl_f0", 1, 1, 2, 32'h2FF, 1, 14, 32'hA4, 0, 0,  1, 10, 32'hA0, 1, 0, 0);
    cyc("fl_f1", 1, 1, 2, 32'h2FF, 0, 0, 0,       0, 0,  1, 11, 32'hA1, 1, 1, 0);
    cyc("fl_f2", 1, 1, 2, 32'h2FF, 0, 0, 0,       0, 0,  1, 12, 32'hA2, 1, 1, 0);
    cyc("fl_f3", 1, 1, 2, 32'h2FF, 0, 0, 0,       0, 0,  1, 13, 32'hA3, 1, 1, 0);
    cyc("fl_wb", 1, 1, 2, 32'h2FF, 0, 0, 0,       0, 0,  1, 2,  32'h2FF, 0, 1, 0);

    // 5: hazard check on rs1/rs2, x0 never pending, llu_rd=0 dropped.
    cyc("hz_acc", 1, 0, 0, 0,       1, 3, 32'h33,  3, 0,  0, 0, 0,      0, 1, 0);
    cyc("hz_rs1", 1, 1, 4, 32'h44,  1, 0, 32'hBAD, 3, 0,  1, 4, 32'h44, 0, 1, 1);
    cyc("hz_rs2", 1, 1, 4, 32'h45,  0, 0, 0,       0, 3,  1, 4, 32'h45, 0, 1, 1);
    cyc("hz_x0",  1, 0, 0, 0,       0, 0, 0,       0, 0,  1, 3, 32'h33, 0, 1, 0);
    cyc("hz_idl", 1, 0, 0, 0,       0, 0, 0,       0, 0,  0, 0, 0,      0, 1, 0);

    // 7: push and pop in the same cycle keeps FIFO order.
    cyc("pp_a", 1, 0, 0, 0, 1, 24, 32'hE0, 0, 0,  0, 0,  0,      0, 1, 0);
    cyc("pp_b", 1, 0, 0, 0, 1, 25, 32'hE1, 0, 0,  1, 24, 32'hE0, 0, 1, 0);
    cyc("pp_c", 1, 0, 0, 0, 0, 0,  0,      0, 0,  1, 25, 32'hE1, 0, 1, 0);
    cyc("pp_d", 1, 0, 0, 0, 0, 0,  0,      0, 0,  0, 0,  0,      0, 1, 0);

    // 6: reset with three queued entries discards them.
    cyc("rq_a0", 1, 1, 1, 32'h1, 1, 21, 32'hC1, 21, 0,  1, 1, 32'h1, 0, 1, 0);
    cyc("rq_a1", 1, 1, 1, 32'h2, 1, 22, 32'hC2, 21, 0,  1, 1, 32'h2, 0, 1, 1);
    cyc("rq_a2", 1, 1, 1, 32'h3, 1, 23, 32'hC3, 21, 0,  1, 1, 32'h3, 0, 1, 1);
    cyc("rq_rst", 0, 1, 1, 32'h4, 0, 0, 0,     21, 0,  0, 0, 0,     0, 1, 0);
    cyc("rq_p0", 1, 0, 0, 0,      0, 0, 0,     21, 0,  0, 0, 0,     0, 1, 0);
    cyc("rq_p1", 1, 0, 0, 0,      0, 0, 0,     22, 23, 0, 0, 0,     0, 1, 0);
    cyc("rq_p2", 1, 0, 0, 0,      0, 0, 0,     0,  0,  0, 0, 0,     0, 1, 0);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
